sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//   Memory-side responder for the core's two SRAM-style initiator ports (inst_sram_*, data_sram_*).
//   Both ports share one word-addressed backing array with byte-lane write enables and a fixed one-cycle read latency.
//   Sits in the SoC-lite wrapper and simulation bench directly opposite mycpu_core's fetch and load/store ports.
//   Adds sticky out-of-range flags and saturating access counters for debug.
// PARAMETERS
//   ADDR_W     16            word-index width; array depth = 2**ADDR_W words
//   BASE_ADDR  32'h0000_0000 byte address of word 0; low 2 bits must be 0
//   CNT_W      32            width of each access counter
// PORTS
//   clk              in   1       single clock; all state updates on posedge
//   rst              in   1       asynchronous, active-high reset
//   inst_sram_en     in   1       fetch-port access request, this cycle
//   inst_sram_wen    in   4       fetch-port byte write enables (normally 0)
//   inst_sram_addr   in   32      fetch-port byte address
//   inst_sram_wdata  in   32      fetch-port write data
//   inst_sram_rdata  out  32      fetch-port read data, valid cycle after request
//   data_sram_en     in   1       data-port access request
//   data_sram_wen    in   4       data-port byte write enables; bit i -> wdata[8i+7:8i]
//   data_sram_addr   in   32      data-port byte address
//   data_sram_wdata  in   32      data-port write data
//   data_sram_rdata  out  32      data-port read data, valid cycle after request
//   inst_oor         out  1       sticky: fetch port accessed outside array
//   data_oor         out  1       sticky: data port accessed outside array
//   rd_cnt           out  CNT_W   count of in-range read accesses (both ports)
//   wr_cnt           out  CNT_W   count of in-range write accesses (both ports)
// BEHAVIOUR
//   - Reset (async, rst=1): both rdata=0, inst_oor=data_oor=0, rd_cnt=wr_cnt=0. Array contents NOT reset.
//   - Decode: off = addr - BASE_ADDR; idx = off[ADDR_W+1:2]; in-range iff off[31:ADDR_W+2]==0. addr[1:0] ignored.
//   - Read: en=1 & wen=0 & in-range -> rdata <= mem[idx] at posedge; visible next cycle (latency 1).
//   - Write: en=1 & wen!=0 & in-range -> lanes with wen[i]=1 updated at posedge; rdata <= 0 for that cycle.
//   - en=0: rdata holds previous value; no counter change.
//   - Out-of-range with en=1: no array write; rdata <= 0; port oor flag set, stays set until reset.
//   - Same-cycle collision, one port writes word X, other reads X: reader gets OLD contents (read-before-write).
//   - Both ports write word X same cycle: per lane, data-port lane wins where data_sram_wen[i]=1; else inst lane.
//   - Counters: +1 per in-range access per port; both ports same cycle -> +2 (or +1 each to rd/wr as classified).
//     Saturate at all-ones; never wrap.
//   - rst asserted mid-access: pending rdata update discarded; outputs forced to reset values immediately.
// STRUCTURE
//   - lib/defines.vh gains: SRAM_ADDR_WD (32), SRAM_DATA_WD (32), SRAM_WEN_WD (4).
//   - Sub-module sram_resp_port (instantiated twice): address decode, in-range flag, rdata register,
//     sticky oor flag, per-port read/write strobes. Top holds array, lane-merge write logic, counters.
// TESTING
//   1. Reset then idle: rdata=0, oor=0, rd_cnt=wr_cnt=0; rdata stays 0 with en=0 for 10 cycles.
//   2. data write addr 0x10 wen=4'hF wdata=0xDEADBEEF; next cycle data read 0x10 -> rdata 0xDEADBEEF one cycle later; wr_cnt=1, rd_cnt=1.
//   3. Byte lanes: write 0x11223344 wen=F, then wen=4'b0010 wdata=0x0000AA00 to same addr -> read 0x1122AA44.
//   4. Collision: inst read 0x20 (holds 0x1) while data writes 0x20 = 0x2 -> inst rdata 0x1; next inst read -> 0x2.
//   5. Out-of-range: data read BASE_ADDR + 4*2**ADDR_W -> rdata 0, data_oor=1 sticky, counters unchanged; array unmodified.
//   6. Saturation/reset: preload rd_cnt near max via force, read twice -> stays all-ones; assert rst mid-read -> rdata 0 same cycle.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared widths and helpers for the SRAM responder slice.
package sram_responder_pkg;

    localparam int SRAM_ADDR_WD = 32;
    localparam int SRAM_DATA_WD = 32;
    localparam int SRAM_WEN_WD  = 4;

    // Number of strobes asserted this cycle (0..2), used to step the shared counters.
    function automatic logic [1:0] strobe_cnt(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/sram_resp_port.sv
// One initiator port: address decode, range check, registered read data, sticky out-of-range flag.
// Latency: rdata updates on the posedge after a request; decode and strobes are combinational.
// Backpressure: none, every request is accepted in the cycle it is presented.
module sram_resp_port
    import sram_responder_pkg::*;
#(
    parameter int                      ADDR_W    = 16,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [SRAM_WEN_WD-1:0]  wen,
    input  logic [SRAM_ADDR_WD-1:0] addr,
    input  logic [SRAM_DATA_WD-1:0] mem_rdata,
    output logic [ADDR_W-1:0]       idx,
    output logic                    rd_stb,
    output logic                    wr_stb,
    output logic [SRAM_DATA_WD-1:0] rdata,
    output logic                    oor
);

    logic [SRAM_ADDR_WD-1:0] off;
    logic                    in_range;

    assign off      = addr - BASE_ADDR;
    assign idx      = off[ADDR_W+1:2];
    // A shift keeps the check valid even when the array spans the whole address space.
    assign in_range = (off >> (ADDR_W + 2)) == '0;
    assign rd_stb   = en && in_range && (wen == '0);
    assign wr_stb   = en && in_range && (wen != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            oor   <= 1'b0;
        end else if (en) begin
            rdata <= rd_stb ? mem_rdata : '0;
            if (!in_range) begin
                oor <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Dual-port SRAM responder: shared word array with byte-lane writes, plus saturating access counters.
// Latency: one cycle read on both ports; reads observe pre-write contents on same-cycle collisions.
// Backpressure: none, both ports are serviced every cycle.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int                      ADDR_W    = 16,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                      CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_sram_en,
    input  logic [SRAM_WEN_WD-1:0]  inst_sram_wen,
    input  logic [SRAM_ADDR_WD-1:0] inst_sram_addr,
    input  logic [SRAM_DATA_WD-1:0] inst_sram_wdata,
    output logic [SRAM_DATA_WD-1:0] inst_sram_rdata,
    input  logic                    data_sram_en,
    input  logic [SRAM_WEN_WD-1:0]  data_sram_wen,
    input  logic [SRAM_ADDR_WD-1:0] data_sram_addr,
    input  logic [SRAM_DATA_WD-1:0] data_sram_wdata,
    output logic [SRAM_DATA_WD-1:0] data_sram_rdata,
    output logic                    inst_oor,
    output logic                    data_oor,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic [CNT_W-1:0]        wr_cnt
);

    logic [SRAM_DATA_WD-1:0] mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] inst_idx, data_idx;
    logic              inst_rd, inst_wr, data_rd, data_wr;
    logic [CNT_W:0]    rd_sum, wr_sum;

    sram_resp_port #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_inst_port (
        .clk       (clk),
        .rst       (rst),
        .en        (inst_sram_en),
        .wen       (inst_sram_wen),
        .addr      (inst_sram_addr),
        .mem_rdata (mem[inst_idx]),
        .idx       (inst_idx),
        .rd_stb    (inst_rd),
        .wr_stb    (inst_wr),
        .rdata     (inst_sram_rdata),
        .oor       (inst_oor)
    );

    sram_resp_port #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_data_port (
        .clk       (clk),
        .rst       (rst),
        .en        (data_sram_en),
        .wen       (data_sram_wen),
        .addr      (data_sram_addr),
        .mem_rdata (mem[data_idx]),
        .idx       (data_idx),
        .rd_stb    (data_rd),
        .wr_stb    (data_wr),
        .rdata     (data_sram_rdata),
        .oor       (data_oor)
    );

    // Contents are deliberately not reset. The data-port loop comes second so its lanes win.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRAM_WEN_WD; i++) begin
            if (inst_wr && inst_sram_wen[i]) begin
                mem[inst_idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
            end
        end
        for (int i = 0; i < SRAM_WEN_WD; i++) begin
            if (data_wr && data_sram_wen[i]) begin
                mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign rd_sum = {1'b0, rd_cnt} + (CNT_W+1)'(strobe_cnt(inst_rd, data_rd));
    assign wr_sum = {1'b0, wr_cnt} + (CNT_W+1)'(strobe_cnt(inst_wr, data_wr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            rd_cnt <= rd_sum[CNT_W] ? '1 : rd_sum[CNT_W-1:0];
            wr_cnt <= wr_sum[CNT_W] ? '1 : wr_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table, randomized traffic against a reference model,
// then counter saturation and asynchronous reset during a read.
module tb_sram_responder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam logic [31:0] LIMIT = 32'h1000;  // 4 * 2**ADDR_W bytes with base 0
    localparam int WIN_WORD = 64;               // random traffic window: words 64..79
    localparam int WIN_N    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [3:0]  inst_sram_wen = '0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_wdata = '0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = '0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [31:0] data_sram_rdata;
    logic        inst_oor, data_oor;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .inst_oor        (inst_oor),
        .data_oor        (data_oor),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ie; logic [3:0] iw; logic [31:0] ia; logic [31:0] id;
        logic de; logic [3:0] dw; logic [31:0] da; logic [31:0] dd;
        logic [31:0] eir; logic [31:0] edr; logic eio; logic edo; int erd; int ewr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
        input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
        input logic [31:0] eir, input logic [31:0] edr, input logic eio, input logic edo,
        input int erd, input int ewr);
        vec_t v;
        v.ie = ie; v.iw = iw; v.ia = ia; v.id = id;
        v.de = de; v.dw = dw; v.da = da; v.dd = dd;
        v.eir = eir; v.edr = edr; v.eio = eio; v.edo = edo; v.erd = erd; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(
        input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
        input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Reference model state
    logic [31:0] mm [WIN_N];
    logic [31:0] m_ir, m_dr;
    logic        m_io, m_do;
    int          m_rd, m_wr;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Predict one cycle of both ports from the behavioural rules.
    task automatic model_cycle(
        input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
        input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        logic i_in, d_in;
        int   iwd, dwd;
        i_in = ia < LIMIT;
        d_in = da < LIMIT;
        iwd  = int'(ia / 4) - WIN_WORD;
        dwd  = int'(da / 4) - WIN_WORD;
        if (ie) begin
            m_ir = (i_in && iw == 0) ? mm[iwd] : 32'h0;
            if (!i_in) m_io = 1'b1;
            if (i_in) begin
                if (iw == 0) m_rd = sat(m_rd + 1); else m_wr = sat(m_wr + 1);
            end
        end
        if (de) begin
            m_dr = (d_in && dw == 0) ? mm[dwd] : 32'h0;
            if (!d_in) m_do = 1'b1;
            if (d_in) begin
                if (dw == 0) m_rd = sat(m_rd + 1); else m_wr = sat(m_wr + 1);
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (de && d_in && dw[b]) mm[dwd][8*b +: 8] = dd[8*b +: 8];
            else if (ie && i_in && iw[b] && !(de && d_in && dwd == iwd && dw[b])) begin
                if (!(de && d_in && dwd == iwd && dw[b])) mm[iwd][8*b +: 8] = id[8*b +: 8];
            end
        end
        // An inst write to a word the data port also writes is handled per lane above;
        // when the words differ, the inst lanes still need applying.
        for (int b = 0; b < 4; b++) begin
            if (ie && i_in && iw[b] && !(de && d_in && dwd == iwd && dw[b]))
                mm[iwd][8*b +: 8] = id[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = LIMIT + ($urandom % 32'hFFFF_E000);
        else a = 32'((WIN_WORD + $urandom_range(0, WIN_N - 1)) * 4 + $urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic ie, de;
        logic [3:0] iw, dw;
        logic [31:0] ia, da, id, dd;

        tbl[0]  = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 1);
        tbl[1]  = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'h0, 32'h10,   32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 1, 1);
        tbl[2]  = mk(0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 32'h0,    32'h0,        32'h0,        32'hDEADBEEF, 0, 0, 1, 1);
        tbl[3]  = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'hF, 32'h14,   32'h11223344, 32'h0,        32'h0,        0, 0, 1, 2);
        tbl[4]  = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'h2, 32'h14,   32'h0000AA00, 32'h0,        32'h0,        0, 0, 1, 3);
        tbl[5]  = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'h0, 32'h16,   32'h0,        32'h0,        32'h1122AA44, 0, 0, 2, 3);
        tbl[6]  = mk(1, 4'hF, 32'h20,       32'h1,        0, 4'h0, 32'h0,    32'h0,        32'h0,        32'h1122AA44, 0, 0, 2, 4);
        tbl[7]  = mk(1, 4'h0, 32'h20,       32'h0,        1, 4'hF, 32'h20,   32'h2,        32'h1,        32'h0,        0, 0, 3, 5);
        tbl[8]  = mk(1, 4'h0, 32'h20,       32'h0,        0, 4'h0, 32'h0,    32'h0,        32'h2,        32'h0,        0, 0, 4, 5);
        tbl[9]  = mk(1, 4'hF, 32'h24,       32'hAAAAAAAA, 1, 4'h5, 32'h24,   32'h11223344, 32'h0,        32'h0,        0, 0, 4, 7);
        tbl[10] = mk(1, 4'h0, 32'h24,       32'h0,        1, 4'h0, 32'h24,   32'h0,        32'hAA22AA44, 32'hAA22AA44, 0, 0, 6, 7);
        tbl[11] = mk(0, 4'h0, 32'h0,        32'h0,        1, 4'h0, 32'h1000, 32'h0,        32'hAA22AA44, 32'h0,        0, 1, 6, 7);
        tbl[12] = mk(1, 4'h0, 32'hFFFFFFF0, 32'h0,        1, 4'hF, 32'h2010, 32'h55555555, 32'h0,        32'h0,        1, 1, 6, 7);
        tbl[13] = mk(0, 4'h0, 32'h0,        32'h0,        0, 4'h0, 32'h0,    32'h0,        32'h0,        32'h0,        1, 1, 6, 7);
        tbl[14] = mk(1, 4'h0, 32'h10,       32'h0,        1, 4'h0, 32'h1010, 32'h0,        32'hDEADBEEF, 32'h0,        1, 1, 7, 7);
        tbl[15] = mk(1, 4'h0, 32'h2010,     32'h0,        1, 4'h0, 32'h14,   32'h0,        32'h0,        32'h1122AA44, 1, 1, 8, 7);

        // Reset and idle
        repeat (3) step();
        chk("rst inst_rdata", inst_sram_rdata, 32'h0);
        chk("rst data_rdata", data_sram_rdata, 32'h0);
        chk("rst oor", {30'h0, inst_oor, data_oor}, 32'h0);
        chk("rst rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst wr_cnt", 32'(wr_cnt), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle rdata", inst_sram_rdata | data_sram_rdata, 32'h0);
        end

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].ie, tbl[i].iw, tbl[i].ia, tbl[i].id, tbl[i].de, tbl[i].dw, tbl[i].da, tbl[i].dd);
            step();
            chk($sformatf("vec%0d inst_rdata", i), inst_sram_rdata, tbl[i].eir);
            chk($sformatf("vec%0d data_rdata", i), data_sram_rdata, tbl[i].edr);
            chk($sformatf("vec%0d oor", i), {30'h0, inst_oor, data_oor}, {30'h0, tbl[i].eio, tbl[i].edo});
            chk($sformatf("vec%0d rd_cnt", i), 32'(rd_cnt), 32'(tbl[i].erd));
            chk($sformatf("vec%0d wr_cnt", i), 32'(wr_cnt), 32'(tbl[i].ewr));
        end

        // Reset clears flags but not contents
        pulse_reset();
        chk("rerst oor", {30'h0, inst_oor, data_oor}, 32'h0);
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
        step();
        chk("mem kept over reset", data_sram_rdata, 32'hDEADBEEF);

        // Randomized traffic against the model
        pulse_reset();
        m_ir = 0; m_dr = 0; m_io = 0; m_do = 0; m_rd = 0; m_wr = 0;
        for (int w = 0; w < WIN_N; w++) begin
            dd = $urandom | 32'h1;
            mm[w] = dd;
            drive(0, 0, 0, 0, 1, 4'hF, 32'((WIN_WORD + w) * 4), dd);
            m_wr = sat(m_wr + 1);
            m_dr = 0;
            step();
        end
        for (int c = 0; c < 300; c++) begin
            ie = ($urandom_range(0, 3) != 0);
            de = ($urandom_range(0, 3) != 0);
            iw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            dw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            ia = rand_addr(); da = rand_addr();
            id = $urandom; dd = $urandom;
            drive(ie, iw, ia, id, de, dw, da, dd);
            model_cycle(ie, iw, ia, id, de, dw, da, dd);
            step();
            chk("rnd inst_rdata", inst_sram_rdata, m_ir);
            chk("rnd data_rdata", data_sram_rdata, m_dr);
            chk("rnd oor", {30'h0, inst_oor, data_oor}, {30'h0, m_io, m_do});
            chk("rnd rd_cnt", 32'(rd_cnt), 32'(m_rd));
            chk("rnd wr_cnt", 32'(wr_cnt), 32'(m_wr));
        end

        // Counter saturation
        pulse_reset();
        drive(1, 0, 32'h100, 0, 1, 0, 32'h100, 0);
        repeat ((CMAX - 1) / 2) step();
        chk("sat rd before", 32'(rd_cnt), 32'(CMAX - 1));
        step();
        chk("sat rd +2 clamp", 32'(rd_cnt), 32'(CMAX));
        drive(0, 0, 0, 0, 1, 0, 32'h100, 0);
        step();
        chk("sat rd held", 32'(rd_cnt), 32'(CMAX));
        chk("sat read data", data_sram_rdata, mm[0]);
        chk("sat wr untouched", 32'(wr_cnt), 32'h0);

        // Asynchronous reset during an active read
        #3;
        rst = 1'b1;
        #1;
        chk("async rst data_rdata", data_sram_rdata, 32'h0);
        chk("async rst rd_cnt", 32'(rd_cnt), 32'h0);
        step();
        chk("held rst data_rdata", data_sram_rdata, 32'h0);
        rst = 1'b0;
        step();
        chk("post rst read", data_sram_rdata, mm[0]);
        chk("post rst rd_cnt", 32'(rd_cnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
